// File: rtl/interp_pkg.sv
// Shared constants for the interpolator family: mode encodings, default widths, pipeline depth.
package interp_pkg;

    localparam int unsigned INTERP_INW     = 28;
    localparam int unsigned INTERP_CTRBITS = 32;
    localparam int unsigned INTERP_MPYBITS = 16;
    localparam int unsigned INTERP_LATENCY = 4;

    typedef enum logic {
        INTERP_NEAREST = 1'b0,
        INTERP_LINEAR  = 1'b1
    } interp_mode_e;

endpackage

// File: rtl/interp_mpy.sv
// Registered signed x unsigned multiplier; kept separate so a DSP-mapped version can replace it.
module interp_mpy #(
    parameter int unsigned AW = 29,
    parameter int unsigned BW = 16
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic                 i_ce,
    input  logic signed [AW-1:0] i_a,
    input  logic        [BW-1:0] i_b,
    output logic signed [AW+BW:0] o_p
);

    // Both operands widened to the product width so the multiply wraps correctly.
    logic signed [AW+BW:0] a_ext;
    logic signed [AW+BW:0] b_ext;

    assign a_ext = {{(BW+1){i_a[AW-1]}}, i_a};
    assign b_ext = {{(AW+1){1'b0}}, i_b};

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_p <= '0;
        end else if (i_ce) begin
            o_p <= a_ext * b_ext;
        end
    end

endmodule

// File: rtl/linearinterp.sv
// Rate-raising nearest/linear interpolator with phase accumulator and two-sample history.
// Define LINEARINTERP_ROUND_EN for round-half-up in linear mode (default: truncate toward -inf).
module linearinterp
    import interp_pkg::*;
#(
    parameter int unsigned INW     = INTERP_INW,
    parameter int unsigned CTRBITS = INTERP_CTRBITS,
    parameter int unsigned MPYBITS = INTERP_MPYBITS
) (
    input  logic                  i_clk,
    input  logic                  i_areset_n,
    input  logic                  i_ce,
    input  logic [CTRBITS-1:0]    i_step,
    input  logic                  i_mode,
    input  logic                  i_valid,
    input  logic signed [INW-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_ce,
    output logic signed [INW-1:0] o_data,
    output logic                  o_underflow
);

    localparam int unsigned PW = INW + MPYBITS + 2;

    logic [CTRBITS-1:0]    r_phase;
    logic signed [INW-1:0] r_x0, r_x1;
    logic [CTRBITS:0]      phase_sum;
    logic                  carry;
    logic signed [INW-1:0] x0_nxt, x1_nxt;

    logic                  s1_valid, s1_mode;
    logic [MPYBITS-1:0]    s1_frac;
    logic signed [INW-1:0] s1_x0, s1_x1;

    logic                  s2_valid, s2_mode;
    logic [MPYBITS-1:0]    s2_frac;
    logic signed [INW:0]   s2_diff;
    logic signed [INW-1:0] s2_x0, s2_x1;

    logic                  s3_valid, s3_mode, s3_half;
    logic signed [INW-1:0] s3_x0, s3_x1;
    logic signed [PW-1:0]  s3_prod, prod_adj;
    logic signed [INW-1:0] lin;

    assign phase_sum = {1'b0, r_phase} + {1'b0, i_step};
    assign carry     = phase_sum[CTRBITS];
    assign o_ready   = i_ce & carry & i_valid;

    // Stage 1 sees the history as it will be after this strobe's update.
    assign x0_nxt = o_ready ? r_x1   : r_x0;
    assign x1_nxt = o_ready ? i_data : r_x1;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_phase     <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            o_underflow <= 1'b0;
            s1_valid    <= 1'b0;
            s1_mode     <= 1'b0;
            s1_frac     <= '0;
            s1_x0       <= '0;
            s1_x1       <= '0;
            s2_valid    <= 1'b0;
            s2_mode     <= 1'b0;
            s2_frac     <= '0;
            s2_diff     <= '0;
            s2_x0       <= '0;
            s2_x1       <= '0;
            s3_valid    <= 1'b0;
            s3_mode     <= 1'b0;
            s3_half     <= 1'b0;
            s3_x0       <= '0;
            s3_x1       <= '0;
            o_ce        <= 1'b0;
            o_data      <= '0;
        end else begin
            if (i_ce) begin
                r_phase <= phase_sum[CTRBITS-1:0];
                r_x0    <= x0_nxt;
                r_x1    <= x1_nxt;
                s1_frac <= phase_sum[CTRBITS-1 -: MPYBITS];
                s1_x0   <= x0_nxt;
                s1_x1   <= x1_nxt;
                s1_mode <= i_mode;
            end
            if (i_ce && carry && !i_valid) begin
                o_underflow <= 1'b1;
            end
            s1_valid <= i_ce;

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_diff <= {s1_x1[INW-1], s1_x1} - {s1_x0[INW-1], s1_x0};
                s2_frac <= s1_frac;
                s2_x0   <= s1_x0;
                s2_x1   <= s1_x1;
                s2_mode <= s1_mode;
            end

            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_half <= s2_frac[MPYBITS-1];
                s3_x0   <= s2_x0;
                s3_x1   <= s2_x1;
                s3_mode <= s2_mode;
            end

            o_ce <= s3_valid;
            if (s3_valid) begin
                if (s3_mode == INTERP_LINEAR) begin
                    o_data <= lin;
                end else begin
                    o_data <= s3_half ? s3_x1 : s3_x0;
                end
            end
        end
    end

    interp_mpy #(
        .AW (INW + 1),
        .BW (MPYBITS)
    ) u_mpy (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_ce       (s2_valid),
        .i_a        (s2_diff),
        .i_b        (s2_frac),
        .o_p        (s3_prod)
    );

`ifdef LINEARINTERP_ROUND_EN
    assign prod_adj = s3_prod + {{(PW-MPYBITS){1'b0}}, 1'b1, {(MPYBITS-1){1'b0}}};
`else
    assign prod_adj = s3_prod;
`endif

    // Convex combination of x0 and x1, so the truncated sum always fits INW.
    assign lin = s3_x0 + INW'(prod_adj >>> MPYBITS);

endmodule

// File: tb/tb_linearinterp.sv
// Directed-vector bench for linearinterp: strobe table, output scoreboard, mid-stream reset.
module tb_linearinterp;

`ifdef LINEARINTERP_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic               i_clk = 1'b0;
    logic               i_areset_n = 1'b0;
    logic               i_ce = 1'b0;
    logic [31:0]        i_step = '0;
    logic               i_mode = 1'b0;
    logic               i_valid = 1'b0;
    logic signed [27:0] i_data = '0;
    logic               o_ready;
    logic               o_ce;
    logic signed [27:0] o_data;
    logic               o_underflow;

    linearinterp #(
        .INW     (28),
        .CTRBITS (32),
        .MPYBITS (16)
    ) dut (
        .i_clk       (i_clk),
        .i_areset_n  (i_areset_n),
        .i_ce        (i_ce),
        .i_step      (i_step),
        .i_mode      (i_mode),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_ce        (o_ce),
        .o_data      (o_data),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        string              name;
        bit                 rst;
        logic [31:0]        step;
        logic               mode;
        logic               valid;
        logic signed [27:0] data;
        logic               exp_ready;
        logic               exp_uf;
        logic signed [27:0] exp_out;
    } vec_t;

    typedef struct {
        logic signed [27:0] val;
        int                 cyc;
        string              name;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input bit rst, input logic [31:0] step,
                                input bit mode, input bit valid, input int data,
                                input bit rdy, input bit uf, input int out);
        vec_t v;
        v.name = n; v.rst = rst; v.step = step; v.mode = mode; v.valid = valid;
        v.data = 28'(data); v.exp_ready = rdy; v.exp_uf = uf; v.exp_out = 28'(out);
        return v;
    endfunction

    // Output scoreboard: each o_ce must match the oldest pending strobe, 4 cycles later.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_ce) begin
            if (expq.size() == 0) begin
                check("spurious o_ce", 1, 0);
            end else begin
                e = expq.pop_front();
                check({e.name, " data"}, int'(o_data), int'(e.val));
                check({e.name, " latency"}, cyc - e.cyc, 4);
            end
        end
    end

    task automatic do_reset();
        i_ce = 1'b0;
        i_valid = 1'b0;
        repeat (6) @(posedge i_clk);
        #1;
        check("drain before reset", expq.size(), 0);
        @(negedge i_clk);
        i_areset_n = 1'b0;
        expq.delete();
        @(negedge i_clk);
        i_areset_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        if (v.rst) do_reset();
        i_step = v.step; i_mode = v.mode; i_valid = v.valid; i_data = v.data;
        i_ce = 1'b1;
        #1;
        check({v.name, " ready"}, int'(o_ready), int'(v.exp_ready));
        e.val = v.exp_out; e.cyc = cyc; e.name = v.name;
        expq.push_back(e);
        @(posedge i_clk);
        #1;
        check({v.name, " underflow"}, int'(o_underflow), int'(v.exp_uf));
        i_ce = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    localparam logic [31:0] HALF = 32'h8000_0000;

    initial begin
        // Linear, half step
        vecs.push_back(mk("lin1", 1, HALF, 1, 1, 100, 0, 0, 0));
        vecs.push_back(mk("lin2", 0, HALF, 1, 1, 100, 1, 0, 0));
        vecs.push_back(mk("lin3", 0, HALF, 1, 1, 200, 0, 0, 50));
        vecs.push_back(mk("lin4", 0, HALF, 1, 1, 200, 1, 0, 100));
        vecs.push_back(mk("lin5", 0, HALF, 1, 1, 300, 0, 0, 150));
        vecs.push_back(mk("lin6", 0, HALF, 1, 1, 300, 1, 0, 200));
        vecs.push_back(mk("lin7", 0, HALF, 1, 1, 300, 0, 0, 250));
        // Nearest, same stimulus
        vecs.push_back(mk("nn1", 1, HALF, 0, 1, 100, 0, 0, 0));
        vecs.push_back(mk("nn2", 0, HALF, 0, 1, 100, 1, 0, 0));
        vecs.push_back(mk("nn3", 0, HALF, 0, 1, 200, 0, 0, 100));
        vecs.push_back(mk("nn4", 0, HALF, 0, 1, 200, 1, 0, 100));
        vecs.push_back(mk("nn5", 0, HALF, 0, 1, 300, 0, 0, 200));
        vecs.push_back(mk("nn6", 0, HALF, 0, 1, 300, 1, 0, 200));
        vecs.push_back(mk("nn7", 0, HALF, 0, 1, 300, 0, 0, 300));
        // Rounding at frac 0x8000 between 0 and -1, then 0 and +1
        vecs.push_back(mk("rneg1", 1, HALF, 1, 1, -1, 0, 0, 0));
        vecs.push_back(mk("rneg2", 0, HALF, 1, 1, -1, 1, 0, 0));
        vecs.push_back(mk("rneg3", 0, HALF, 1, 1, -1, 0, 0, RND ? 0 : -1));
        vecs.push_back(mk("rpos1", 1, HALF, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk("rpos2", 0, HALF, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk("rpos3", 0, HALF, 1, 1, 1, 0, 0, RND ? 1 : 0));
        // Underflow: held samples repeat, later data still consumed, flag sticky
        vecs.push_back(mk("uf1", 1, HALF, 1, 1, 100, 0, 0, 0));
        vecs.push_back(mk("uf2", 0, HALF, 1, 1, 100, 1, 0, 0));
        vecs.push_back(mk("uf3", 0, HALF, 1, 1, 200, 0, 0, 50));
        vecs.push_back(mk("uf4", 0, HALF, 1, 0, 200, 0, 1, 0));
        vecs.push_back(mk("uf5", 0, HALF, 1, 0, 200, 0, 1, 50));
        vecs.push_back(mk("uf6", 0, HALF, 1, 1, 200, 1, 1, 100));
        vecs.push_back(mk("uf7", 0, HALF, 1, 1, 300, 0, 1, 150));
        // Mode switching per strobe
        vecs.push_back(mk("mix1", 1, HALF, 1, 1, 100, 0, 0, 0));
        vecs.push_back(mk("mix2", 0, HALF, 0, 1, 100, 1, 0, 0));
        vecs.push_back(mk("mix3", 0, HALF, 0, 1, 200, 0, 0, 100));
        vecs.push_back(mk("mix4", 0, HALF, 1, 1, 200, 1, 0, 100));
        vecs.push_back(mk("mix5", 0, HALF, 1, 1, 300, 0, 0, 150));
        vecs.push_back(mk("mix6", 0, HALF, 0, 1, 300, 1, 0, 200));
        vecs.push_back(mk("mix7", 0, HALF, 0, 1, 300, 0, 0, 300));
        // Maximum step on a ramp: one input per strobe, frac 0xFFFF
        vecs.push_back(mk("ramp1", 1, 32'hFFFF_FFFF, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk("ramp2", 0, 32'hFFFF_FFFF, 1, 1, 1, 1, 0, RND ? 1 : 0));
        vecs.push_back(mk("ramp3", 0, 32'hFFFF_FFFF, 1, 1, 2, 1, 0, RND ? 2 : 1));
        vecs.push_back(mk("ramp4", 0, 32'hFFFF_FFFF, 1, 1, 3, 1, 0, RND ? 3 : 2));
        vecs.push_back(mk("ramp5", 0, 32'hFFFF_FFFF, 1, 1, 4, 1, 0, RND ? 4 : 3));
        vecs.push_back(mk("ramp6", 0, 32'hFFFF_FFFF, 1, 1, 5, 1, 0, RND ? 5 : 4));

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-stream reset with outputs pending and underflow set
        apply(mk("mr1", 1, HALF, 1, 1, 1000, 0, 0, 0));
        apply(mk("mr2", 0, HALF, 1, 1, 1000, 1, 0, 0));
        apply(mk("mr3", 0, HALF, 1, 0, 1000, 0, 0, 500));
        apply(mk("mr4", 0, HALF, 1, 0, 1000, 0, 1, 0));
        apply(mk("mr5", 0, HALF, 1, 0, 1000, 0, 1, 500));
        apply(mk("mr6", 0, HALF, 1, 0, 1000, 0, 1, 0));
        @(negedge i_clk);
        #1;
        check("pre-reset o_ce", int'(o_ce), 1);
        check("pre-reset o_data", int'(o_data), 500);
        i_step = 32'hFFFF_FFFF; i_valid = 1'b1; i_ce = 1'b1;
        i_areset_n = 1'b0;
        expq.delete();
        #1;
        check("reset o_ce", int'(o_ce), 0);
        check("reset o_data", int'(o_data), 0);
        check("reset o_underflow", int'(o_underflow), 0);
        check("reset o_ready", int'(o_ready), 0);
        i_ce = 1'b0; i_valid = 1'b0;
        @(negedge i_clk);
        i_areset_n = 1'b1;
        repeat (8) @(posedge i_clk);
        #1;
        apply(mk("post1", 0, HALF, 0, 1, 7, 0, 0, 0));
        apply(mk("post2", 0, HALF, 0, 1, 7, 1, 0, 0));
        apply(mk("post3", 0, HALF, 0, 1, 9, 0, 0, 7));

        repeat (8) @(posedge i_clk);
        #1;
        check("final drain", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
